// File: rtl/alsu_cmd_queue.sv
// Command sequencer upstream of the ALSU: a DEPTH-entry command FIFO feeding a
// two-state issue FSM that replays each command for rpt+1 consecutive cycles.
module alsu_cmd_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [19:0]              cmd_data,
  output logic [2:0]               a_o,
  output logic [2:0]               b_o,
  output logic [2:0]               opcode_o,
  output logic                     cin_o,
  output logic                     serial_in_o,
  output logic                     direction_o,
  output logic                     red_op_A_o,
  output logic                     red_op_B_o,
  output logic                     bypass_A_o,
  output logic                     bypass_B_o,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [3:0]    rep_cnt_reg, rep_cnt_next;
  logic [15:0]   out_reg, out_next;
  logic          issue_valid_reg, issue_valid_next;
  state_t        state_reg, state_next;

  logic          push;
  logic          pop;
  logic [19:0]   head;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign cmd_ready = ~full & ~flush;
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem[rd_ptr_reg];

  // Storage has no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= cmd_data;
    end
  end

  always_comb begin
    state_next       = state_reg;
    rep_cnt_next     = rep_cnt_reg;
    out_next         = out_reg;
    issue_valid_next = issue_valid_reg;
    pop              = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop              = 1'b1;
          out_next         = head[15:0];
          rep_cnt_next     = head[19:16];
          issue_valid_next = 1'b1;
          state_next       = ISSUE;
        end else begin
          out_next         = '0;
          issue_valid_next = 1'b0;
        end
      end
      ISSUE: begin
        if (rep_cnt_reg != 4'd0) begin
          rep_cnt_next = rep_cnt_reg - 4'd1;
        end else if (!empty) begin
          // Back-to-back issue: the next command follows with no idle cycle.
          pop              = 1'b1;
          out_next         = head[15:0];
          rep_cnt_next     = head[19:16];
          issue_valid_next = 1'b1;
        end else begin
          out_next         = '0;
          issue_valid_next = 1'b0;
          state_next       = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (flush) begin
      pop              = 1'b0;
      out_next         = '0;
      rep_cnt_next     = '0;
      issue_valid_next = 1'b0;
      state_next       = IDLE;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + CW'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      rep_cnt_reg     <= '0;
      out_reg         <= '0;
      issue_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
      rep_cnt_reg     <= rep_cnt_next;
      out_reg         <= out_next;
      issue_valid_reg <= issue_valid_next;
    end
  end

  assign a_o         = out_reg[2:0];
  assign b_o         = out_reg[5:3];
  assign opcode_o    = out_reg[8:6];
  assign cin_o       = out_reg[9];
  assign serial_in_o = out_reg[10];
  assign direction_o = out_reg[11];
  assign red_op_A_o  = out_reg[12];
  assign red_op_B_o  = out_reg[13];
  assign bypass_A_o  = out_reg[14];
  assign bypass_B_o  = out_reg[15];
  assign issue_valid = issue_valid_reg;
  assign count       = count_reg;

endmodule

// File: tb/tb_alsu_cmd_queue.sv
// Directed bench for alsu_cmd_queue: table of single commands plus hand-written
// back-to-back, repeat, backpressure, flush and async-reset sequences.
module tb_alsu_cmd_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [19:0] cmd_data;
  logic [2:0]  a_o, b_o, opcode_o;
  logic        cin_o, serial_in_o, direction_o;
  logic        red_op_A_o, red_op_B_o, bypass_A_o, bypass_B_o;
  logic        issue_valid;
  logic [3:0]  count;
  logic        full, empty;
  logic [15:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alsu_cmd_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .a_o(a_o), .b_o(b_o), .opcode_o(opcode_o),
    .cin_o(cin_o), .serial_in_o(serial_in_o), .direction_o(direction_o),
    .red_op_A_o(red_op_A_o), .red_op_B_o(red_op_B_o),
    .bypass_A_o(bypass_A_o), .bypass_B_o(bypass_B_o),
    .issue_valid(issue_valid), .count(count), .full(full), .empty(empty)
  );

  assign outs = {bypass_B_o, bypass_A_o, red_op_B_o, red_op_A_o, direction_o,
                 serial_in_o, cin_o, opcode_o, b_o, a_o};

  typedef struct {
    string       name;
    logic [19:0] cmd;
    logic [15:0] exp_out;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  initial begin
    vecs[0] = '{"add_cin",      20'h00293, 16'h0293, 1};
    vecs[1] = '{"shift_rpt5",   20'h50D0D, 16'h0D0D, 6};
    vecs[2] = '{"invalid_op",   20'h1C1FF, 16'hC1FF, 2};
    vecs[3] = '{"reduction",    20'h230F1, 16'h30F1, 3};
    vecs[4] = '{"all_zero",     20'h00000, 16'h0000, 1};
    vecs[5] = '{"all_ones_max", 20'hFFFFF, 16'hFFFF, 16};

    rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    #12;
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_outs", 32'(outs), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Table-driven single commands from an idle, empty queue.
    for (int v = 0; v < 6; v++) begin
      cmd_valid = 1'b1; cmd_data = vecs[v].cmd;
      tick();
      cmd_valid = 1'b0;
      check({vecs[v].name, "_no_bypass"}, 32'(issue_valid), 32'd0);
      check({vecs[v].name, "_count1"}, 32'(count), 32'd1);
      for (int c = 0; c < vecs[v].exp_cycles; c++) begin
        tick();
        check({vecs[v].name, "_valid"}, 32'(issue_valid), 32'd1);
        check({vecs[v].name, "_outs"}, 32'(outs), 32'(vecs[v].exp_out));
      end
      tick();
      check({vecs[v].name, "_end_valid"}, 32'(issue_valid), 32'd0);
      check({vecs[v].name, "_end_outs"}, 32'(outs), 32'd0);
      check({vecs[v].name, "_end_empty"}, 32'(empty), 32'd1);
    end

    // Back-to-back: three rpt=0 commands on consecutive edges.
    cmd_valid = 1'b1; cmd_data = 20'h00001;
    tick();
    check("b2b_first_not_issued", 32'(issue_valid), 32'd0);
    cmd_data = 20'h00002;
    tick();
    check("b2b_a1", 32'(a_o), 32'd1);
    check("b2b_v1", 32'(issue_valid), 32'd1);
    check("b2b_count_pushpop", 32'(count), 32'd1);
    cmd_data = 20'h00003;
    tick();
    cmd_valid = 1'b0;
    check("b2b_a2", 32'(a_o), 32'd2);
    check("b2b_v2", 32'(issue_valid), 32'd1);
    tick();
    check("b2b_a3", 32'(a_o), 32'd3);
    check("b2b_v3", 32'(issue_valid), 32'd1);
    check("b2b_empty", 32'(empty), 32'd1);
    tick();
    check("b2b_end_valid", 32'(issue_valid), 32'd0);

    // Repeat: rpt=5 shift held six cycles, queued command follows directly.
    cmd_valid = 1'b1; cmd_data = 20'h50D0D;
    tick();
    cmd_data = 20'h00006;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("rpt_hold_outs", 32'(outs), 32'h0D0D);
      check("rpt_hold_valid", 32'(issue_valid), 32'd1);
      tick();
    end
    check("rpt_next_outs", 32'(outs), 32'h0006);
    check("rpt_next_valid", 32'(issue_valid), 32'd1);
    tick();
    check("rpt_end_valid", 32'(issue_valid), 32'd0);

    // Backpressure: rpt=15 stall, fill the FIFO, verify no full pass-through.
    cmd_valid = 1'b1; cmd_data = 20'hF0001;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("bp_stall_outs", 32'(outs), 32'h0001);
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1; cmd_data = 20'(8 + i);
      tick();
    end
    check("bp_count8", 32'(count), 32'd8);
    check("bp_full", 32'(full), 32'd1);
    check("bp_not_ready", 32'(cmd_ready), 32'd0);
    cmd_data = 20'h0000F;
    tick();
    cmd_valid = 1'b0;
    check("bp_extra_rejected", 32'(count), 32'd8);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("bp_still_stalled", 32'(outs), 32'h0001);
    end
    tick();
    check("bp_first_pop", 32'(outs), 32'h0008);
    check("bp_count7", 32'(count), 32'd7);
    check("bp_ready_again", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_data = 20'h0000F;
    for (int k = 1; k < 8; k++) begin
      tick();
      cmd_valid = 1'b0;
      check("bp_wrap_order", 32'(outs), 32'(8 + k));
    end
    tick();
    check("bp_wrapped_cmd", 32'(outs), 32'h000F);
    tick();
    check("bp_end_valid", 32'(issue_valid), 32'd0);
    check("bp_end_empty", 32'(empty), 32'd1);

    // Flush during an rpt=10 command with four queued behind it.
    cmd_valid = 1'b1; cmd_data = 20'hA0101;
    tick();
    for (int i = 0; i < 4; i++) begin
      cmd_data = 20'(16 + i);
      tick();
    end
    check("fl_pre_count", 32'(count), 32'd4);
    check("fl_pre_valid", 32'(issue_valid), 32'd1);
    flush = 1'b1; cmd_data = 20'h00007;
    #1;
    check("fl_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    check("fl_valid", 32'(issue_valid), 32'd0);
    check("fl_outs", 32'(outs), 32'd0);
    check("fl_count", 32'(count), 32'd0);
    check("fl_empty", 32'(empty), 32'd1);
    tick();
    check("fl_no_stale_issue", 32'(issue_valid), 32'd0);

    // Asynchronous reset while issuing with a command still queued.
    cmd_valid = 1'b1; cmd_data = 20'hF0123;
    tick();
    cmd_data = 20'h00045;
    tick();
    cmd_valid = 1'b0;
    check("ar_pre_valid", 32'(issue_valid), 32'd1);
    check("ar_pre_count", 32'(count), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid_now", 32'(issue_valid), 32'd0);
    check("ar_outs_now", 32'(outs), 32'd0);
    check("ar_count_now", 32'(count), 32'd0);
    tick();
    rst = 1'b0;
    cmd_valid = 1'b1; cmd_data = 20'h00032;
    tick();
    cmd_valid = 1'b0;
    check("ar_latency_edge1", 32'(issue_valid), 32'd0);
    tick();
    check("ar_latency_edge2_valid", 32'(issue_valid), 32'd1);
    check("ar_latency_edge2_outs", 32'(outs), 32'h0032);
    tick();
    check("ar_end_valid", 32'(issue_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
